// File: rtl/mem_ctrl_rr_pkg.sv
// Shared definitions for the memory-controller family.
//   state_t : controller FSM states (IDLE=0, ISSUE=1, RESP=2; encoding 3 unused)
//   ST_W    : state register width
//   idx_w() : width of a channel index, at least 1 bit so that N_CH=1 still works
package mem_ctrl_rr_pkg;

    localparam int unsigned ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_ctrl_rr_if.sv
// Client and memory-side bus of mem_ctrl_rr.
//   req_valid/req_ready/req_write/req_addr/req_wdata : per-channel request handshake
//   rsp_valid/rsp_rdata/rsp_err                       : one-cycle completion to the owner
//   mem_en/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata: single memory port
//   busy                                              : controller not idle
// Modports: slave = controller view, master = clients plus memory view.
interface mem_ctrl_rr_if #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned AW   = 16,
    parameter int unsigned DW   = 32
) ();
    logic [N_CH-1:0]    req_valid;
    logic [N_CH-1:0]    req_ready;
    logic [N_CH-1:0]    req_write;
    logic [N_CH*AW-1:0] req_addr;
    logic [N_CH*DW-1:0] req_wdata;
    logic [N_CH-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               rsp_err;
    logic               mem_en;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic               mem_ack;
    logic [DW-1:0]      mem_rdata;
    logic               busy;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_ctrl_rr_arbiter.sv
// Round-robin arbiter (combinational).
//   req        : request vector
//   last_grant : index granted most recently; search starts just after it
//   grant      : one-hot winner (0 when no request)
//   grant_idx  : index of the winner (0 when no request)
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);
    always_comb begin
        int unsigned idx;
        logic        found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned off = 1; off <= N; off++) begin
            idx = (32'(last_grant) + off) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end
endmodule

// File: rtl/mem_ctrl_rr.sv
// Multi-channel memory controller: N_CH clients share one memory port through
// a round-robin arbiter. One transaction at a time: accept -> ISSUE (memory
// request held until mem_ack or TIMEOUT cycles) -> RESP (one-cycle pulse).
//   clk, reset : clock, synchronous active-high reset
//   bus        : mem_ctrl_rr_if slave modport (client requests/responses,
//                memory port, busy)
module mem_ctrl_rr
    import mem_ctrl_rr_pkg::*;
#(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           reset,
    mem_ctrl_rr_if.slave   bus
);
    localparam int unsigned IW = idx_w(N_CH);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    state_t          state;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   cur_id;
    logic [CW-1:0]   cnt;
    logic [N_CH-1:0] grant;
    logic [IW-1:0]   grant_idx;

    rr_arbiter #(.N(N_CH), .IW(IW)) u_arb (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    // Arbiter only sees valid channels, so grant is already masked by req_valid.
    assign bus.req_ready = (state == IDLE) ? grant : '0;
    assign bus.busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            last_grant    <= IW'(N_CH - 1);
            cur_id        <= '0;
            cnt           <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        cur_id        <= grant_idx;
                        last_grant    <= grant_idx;
                        cnt           <= '0;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= bus.req_write[grant_idx];
                        bus.mem_addr  <= bus.req_addr[grant_idx*AW +: AW];
                        bus.mem_wdata <= bus.req_wdata[grant_idx*DW +: DW];
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Ack takes precedence over a timeout reached in the same cycle.
                    if (bus.mem_ack) begin
                        bus.mem_en    <= 1'b0;
                        bus.rsp_valid <= N_CH'(1) << cur_id;
                        bus.rsp_rdata <= bus.mem_we ? '0 : bus.mem_rdata;
                        bus.rsp_err   <= 1'b0;
                        state         <= RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        bus.mem_en    <= 1'b0;
                        bus.rsp_valid <= N_CH'(1) << cur_id;
                        bus.rsp_rdata <= '0;
                        bus.rsp_err   <= 1'b1;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    bus.rsp_valid <= '0;
                    bus.rsp_rdata <= '0;
                    bus.rsp_err   <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl_rr.sv
// Self-checking bench for mem_ctrl_rr. A transaction-timeline model predicts,
// for every cycle, req_ready, mem_* and rsp_* from the accept cycle and the
// memory latency chosen by the bench's memory responder.
module tb_mem_ctrl_rr;
    localparam int unsigned N  = 4;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 15;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_ctrl_rr_if #(.N_CH(N), .AW(AW), .DW(DW)) bus ();

    mem_ctrl_rr #(.N_CH(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Client-side pending requests
    logic [N-1:0]  pend_valid = '0;
    logic [N-1:0]  pend_write = '0;
    logic [AW-1:0] pend_addr  [N];
    logic [DW-1:0] pend_wdata [N];
    logic [N-1:0]  taken      = '0;
    bit            refill     = 0;
    bit            rand_mode  = 0;
    bit            reset_req  = 1;

    // Memory responder
    int            lat_q[$];
    logic [DW-1:0] rdata_q[$];
    int            def_lat   = 1;
    int            cur_lat   = 0;
    logic [DW-1:0] cur_rdata = '0;
    int            en_cnt    = 0;

    // Reference model of the single outstanding transaction
    bit            m_active = 0;
    int            m_last   = N - 1;
    int            m_id, m_e, m_eff;
    bit            m_err, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    // Observed activity for directed checks
    int            grant_log[$];
    int            acc_log[$];
    int            en_cycles, rsp_events;
    logic [N-1:0]  last_rsp_valid;
    logic [DW-1:0] last_rsp_rdata;
    logic          last_rsp_err;

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] ready;
    } avec_t;
    avec_t avec[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int i = 1; i <= int'(N); i++) begin
            int c;
            c = (last + i) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic post(input int ch, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend_valid[ch] = 1'b1;
        pend_write[ch] = we;
        pend_addr[ch]  = a;
        pend_wdata[ch] = d;
    endtask

    task automatic clear_stats();
        grant_log.delete();
        acc_log.delete();
        en_cycles      = 0;
        rsp_events     = 0;
        last_rsp_valid = '0;
        last_rsp_rdata = '0;
        last_rsp_err   = 1'b0;
    endtask

    task automatic step();
        int           c, pick, lat;
        bit           in_issue, in_resp;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        c        = cyc;
        in_issue = m_active && (c >= m_e) && (c < m_e + m_eff);
        in_resp  = m_active && (c == m_e + m_eff);
        chk("mem_en", 64'(bus.mem_en), 64'(in_issue));
        chk("busy", 64'(bus.busy), 64'(in_issue || in_resp));
        chk("rsp_valid", 64'(bus.rsp_valid), in_resp ? 64'(N'(1) << m_id) : 64'(0));
        if (in_issue) begin
            chk("mem_we", 64'(bus.mem_we), 64'(m_we));
            chk("mem_addr", 64'(bus.mem_addr), 64'(m_addr));
            chk("mem_wdata", 64'(bus.mem_wdata), 64'(m_wdata));
        end
        if (in_resp) begin
            chk("rsp_err", 64'(bus.rsp_err), 64'(m_err));
            chk("rsp_rdata", 64'(bus.rsp_rdata), (m_we || m_err) ? 64'(0) : 64'(m_rdata));
            m_active = 0;
        end
        if (bus.mem_en === 1'b1) en_cycles++;
        if (bus.rsp_valid !== '0) begin
            rsp_events++;
            last_rsp_valid = bus.rsp_valid;
            last_rsp_rdata = bus.rsp_rdata;
            last_rsp_err   = bus.rsp_err;
        end

        for (int i = 0; i < int'(N); i++) begin
            if (taken[i]) begin
                pend_valid[i] = 1'b0;
                if (refill) post(i, 1'b1, AW'($urandom), $urandom);
            end
        end
        taken = '0;
        if (rand_mode)
            for (int i = 0; i < int'(N); i++)
                if (!pend_valid[i] && $urandom_range(0, 2) == 0)
                    post(i, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);

        if (bus.mem_en === 1'b1) begin
            en_cnt++;
            bus.mem_ack   = (en_cnt == cur_lat);
            bus.mem_rdata = cur_rdata;
        end else begin
            en_cnt        = 0;
            bus.mem_ack   = rand_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
            bus.mem_rdata = $urandom;
        end

        bus.req_valid = reset_req ? '0 : pend_valid;
        bus.req_write = pend_write;
        for (int i = 0; i < int'(N); i++) begin
            bus.req_addr[i*AW +: AW]  = pend_addr[i];
            bus.req_wdata[i*DW +: DW] = pend_wdata[i];
        end
        reset = reset_req;
        #1;

        exp_rdy = '0;
        pick    = -1;
        if (!reset_req && !in_issue && !in_resp) begin
            pick = rr_pick(pend_valid, m_last);
            if (pick >= 0) exp_rdy[pick] = 1'b1;
        end
        chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        taken = bus.req_valid & bus.req_ready;
        for (int i = 0; i < int'(N); i++)
            if (taken[i]) begin
                grant_log.push_back(i);
                acc_log.push_back(c + 1);
            end

        if (pick >= 0) begin
            if (lat_q.size() > 0) lat = lat_q.pop_front();
            else if (rand_mode) begin
                case ($urandom_range(0, 9))
                    0:       lat = 0;
                    1:       lat = TO;
                    2:       lat = TO + 2;
                    default: lat = $urandom_range(1, 4);
                endcase
            end else lat = def_lat;
            cur_lat   = lat;
            cur_rdata = (rdata_q.size() > 0) ? rdata_q.pop_front() : $urandom;
            m_rdata   = cur_rdata;
            m_err     = !(lat >= 1 && lat <= int'(TO));
            m_eff     = m_err ? TO : lat;
            m_id      = pick;
            m_e       = c + 1;
            m_we      = pend_write[pick];
            m_addr    = pend_addr[pick];
            m_wdata   = pend_wdata[pick];
            m_last    = pick;
            m_active  = 1;
        end
        if (reset_req) begin
            m_active = 0;
            m_last   = N - 1;
        end
    endtask

    task automatic do_reset(input int n);
        reset_req = 1;
        repeat (n) step();
        reset_req = 0;
    endtask

    task automatic drain(input int maxc, input string nm);
        int k;
        k = 0;
        while ((pend_valid != '0 || m_active) && k < maxc) begin
            step();
            k++;
        end
        chk({nm, "_drained"}, 64'(k < maxc), 64'(1));
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        for (int i = 0; i < int'(N); i++) begin
            pend_addr[i]  = '0;
            pend_wdata[i] = '0;
        end
        // With last_grant reset to N-1, priority is ch0 first: lowest set bit wins.
        avec[0] = '{4'b0001, 4'b0001};
        avec[1] = '{4'b1000, 4'b1000};
        avec[2] = '{4'b1100, 4'b0100};
        avec[3] = '{4'b1010, 4'b0010};
        avec[4] = '{4'b1111, 4'b0001};
        avec[5] = '{4'b0110, 4'b0010};
        avec[6] = '{4'b0000, 4'b0000};
        avec[7] = '{4'b1001, 4'b0001};

        // Reset state, then 20 idle cycles
        do_reset(3);
        chk("rst_mem_we", 64'(bus.mem_we), 64'(0));
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
        chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'(0));
        chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
        chk("rst_rsp_err", 64'(bus.rsp_err), 64'(0));
        clear_stats();
        repeat (20) step();
        chk("idle_en_cycles", 64'(en_cycles), 64'(0));
        chk("idle_rsp_events", 64'(rsp_events), 64'(0));

        // Arbiter priority right after reset; requests withdrawn before the edge
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.req_valid = avec[i].valid;
            #1;
            chk("arb_tbl", 64'(bus.req_ready), 64'(avec[i].ready));
            bus.req_valid = '0;
        end

        // Single read on ch2, ack on third mem_en cycle
        clear_stats();
        lat_q.push_back(3);
        rdata_q.push_back(32'hDEADBEEF);
        post(2, 1'b0, 16'h0040, '0);
        drain(30, "rd2");
        step();
        chk("rd2_en_cycles", 64'(en_cycles), 64'(3));
        chk("rd2_rsp_events", 64'(rsp_events), 64'(1));
        chk("rd2_rsp_valid", 64'(last_rsp_valid), 64'(4'b0100));
        chk("rd2_rsp_rdata", 64'(last_rsp_rdata), 64'(32'hDEADBEEF));
        chk("rd2_rsp_err", 64'(last_rsp_err), 64'(0));

        // All channels writing continuously, 1-cycle ack
        do_reset(2);
        clear_stats();
        def_lat = 1;
        refill  = 1;
        for (int i = 0; i < int'(N); i++) post(i, 1'b1, AW'(16'h100 + i), 32'hC0DE_0000 + i);
        for (int k = 0; k < 40 && grant_log.size() < 5; k++) step();
        refill = 0;
        chk("rr_grants", 64'(grant_log.size() >= 5), 64'(1));
        if (grant_log.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk("rr_order", 64'(grant_log[i]), 64'(i % N));
            for (int i = 1; i < 5; i++) chk("rr_period", 64'(acc_log[i] - acc_log[i-1]), 64'(3));
        end
        chk("rr_rdata_zero", 64'(last_rsp_rdata), 64'(0));
        pend_valid = '0;
        drain(30, "rr");

        // Timeout on ch1 read, then a normal read
        do_reset(2);
        clear_stats();
        lat_q.push_back(0);
        post(1, 1'b0, 16'h1234, '0);
        drain(40, "to1");
        step();
        chk("to1_en_cycles", 64'(en_cycles), 64'(TO));
        chk("to1_rsp_valid", 64'(last_rsp_valid), 64'(4'b0010));
        chk("to1_rsp_err", 64'(last_rsp_err), 64'(1));
        chk("to1_rsp_rdata", 64'(last_rsp_rdata), 64'(0));
        clear_stats();
        lat_q.push_back(2);
        rdata_q.push_back(32'hA5A5_0001);
        post(0, 1'b0, 16'h0008, '0);
        drain(30, "after_to");
        step();
        chk("after_to_err", 64'(last_rsp_err), 64'(0));
        chk("after_to_rdata", 64'(last_rsp_rdata), 64'(32'hA5A5_0001));
        chk("after_to_valid", 64'(last_rsp_valid), 64'(4'b0001));

        // Reset while ch3 read is in ISSUE
        clear_stats();
        lat_q.push_back(0);
        post(3, 1'b0, 16'h3000, '0);
        for (int k = 0; k < 10 && en_cycles < 3; k++) step();
        chk("rst_mid_reached_issue", 64'(en_cycles >= 3), 64'(1));
        reset_req = 1;
        step();
        reset_req = 0;
        clear_stats();
        step();
        chk("rst_mid_mem_en", 64'(bus.mem_en), 64'(0));
        chk("rst_mid_busy", 64'(bus.busy), 64'(0));
        repeat (3) step();
        chk("rst_mid_no_rsp", 64'(rsp_events), 64'(0));
        lat_q.push_back(1);
        lat_q.push_back(1);
        post(0, 1'b0, 16'h0001, '0);
        post(3, 1'b0, 16'h0003, '0);
        drain(30, "rst_mid");
        chk("rst_mid_grants", 64'(grant_log.size()), 64'(2));
        if (grant_log.size() == 2) begin
            chk("rst_mid_first", 64'(grant_log[0]), 64'(0));
            chk("rst_mid_second", 64'(grant_log[1]), 64'(3));
        end

        // Ack on the same cycle the timeout is reached
        step();
        clear_stats();
        lat_q.push_back(TO);
        rdata_q.push_back(32'h12345678);
        post(2, 1'b0, 16'h0222, '0);
        drain(40, "coinc");
        step();
        chk("coinc_en_cycles", 64'(en_cycles), 64'(TO));
        chk("coinc_err", 64'(last_rsp_err), 64'(0));
        chk("coinc_rdata", 64'(last_rsp_rdata), 64'(32'h12345678));

        // Randomized traffic against the model
        rand_mode = 1;
        repeat (1500) step();
        rand_mode = 0;
        drain(200, "rand");
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
